seq_writeback: RTL and testbench

Write-back stage and architectural register file for the SEQ Y86-64 processor. It is the writing counterpart to decode: it consumes `icode`, `rA`, `rB`, `cnd`, `valE` and `valM` after execute/memory and commits them to the 15 program registers. It also exports every register value to decode and the read ports. It owns the sticky processor status machine (AOK/HLT/ADR/INS), which freezes architectural state once an exception retires, and counts retired instructions.

---
 rtl/seq_writeback.sv | 131 +++++++++++++
 tb/tb_seq_writeback.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_writeback.sv
// SEQ Y86-64 write-back stage: architectural register file, sticky status FSM, retired counter.
// Optional macro WB_BYPASS_EN forwards committing values to the read ports in the same cycle.
module seq_writeback #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [XLEN-1:0]  valE,
  input  logic [XLEN-1:0]  valM,
  input  logic             halt,
  input  logic             invalid_instr,
  input  logic             dmem_error,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [XLEN-1:0]  rdA,
  output logic [XLEN-1:0]  rdB,
  output logic [XLEN-1:0]  rax,
  output logic [XLEN-1:0]  rcx,
  output logic [XLEN-1:0]  rdx,
  output logic [XLEN-1:0]  rbx,
  output logic [XLEN-1:0]  rsp,
  output logic [XLEN-1:0]  rbp,
  output logic [XLEN-1:0]  rsi,
  output logic [XLEN-1:0]  rdi,
  output logic [XLEN-1:0]  r8,
  output logic [XLEN-1:0]  r9,
  output logic [XLEN-1:0]  r10,
  output logic [XLEN-1:0]  r11,
  output logic [XLEN-1:0]  r12,
  output logic [XLEN-1:0]  r13,
  output logic [XLEN-1:0]  r14,
  output logic [2:0]       stat,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_e;

  stat_e             stat_q;
  logic [CNT_W-1:0]  retired_q;
  logic [XLEN-1:0]   regs_q [15];
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic              commit;

  always_comb begin
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (icode)
      4'h3, 4'h6:             dst_e = rB;
      4'h2:                   dst_e = cnd ? rB : REG_NONE;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = REG_RSP;
      default:                dst_e = REG_NONE;
    endcase
    if (icode == 4'h5 || icode == 4'hB) dst_m = rA;
  end

  assign commit = wb_valid && (stat_q == S_AOK) && !halt && !invalid_instr && !dmem_error;

  // Exception priority ADR > INS > HLT; the faulting instruction neither writes nor counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q    <= S_AOK;
      retired_q <= '0;
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else if (wb_valid && stat_q == S_AOK) begin
      if (dmem_error)         stat_q <= S_ADR;
      else if (invalid_instr) stat_q <= S_INS;
      else if (halt)          stat_q <= S_HLT;
      else begin
        if (retired_q != {CNT_W{1'b1}}) retired_q <= retired_q + 1'b1;
        for (int i = 0; i < 15; i++) begin
          if (dst_m == 4'(i))      regs_q[i] <= valM;
          else if (dst_e == 4'(i)) regs_q[i] <= valE;
        end
      end
    end
  end

  always_comb begin
    rdA = '0;
    rdB = '0;
    for (int i = 0; i < 15; i++) begin
      if (srcA == 4'(i)) rdA = regs_q[i];
      if (srcB == 4'(i)) rdB = regs_q[i];
    end
`ifdef WB_BYPASS_EN
    // Forward only a real commit; valM beats valE when both target the same register.
    if (commit && srcA != REG_NONE) begin
      if (srcA == dst_m)      rdA = valM;
      else if (srcA == dst_e) rdA = valE;
    end
    if (commit && srcB != REG_NONE) begin
      if (srcB == dst_m)      rdB = valM;
      else if (srcB == dst_e) rdB = valE;
    end
`endif
  end

  assign stat    = stat_q;
  assign retired = retired_q;
  assign rax = regs_q[0];
  assign rcx = regs_q[1];
  assign rdx = regs_q[2];
  assign rbx = regs_q[3];
  assign rsp = regs_q[4];
  assign rbp = regs_q[5];
  assign rsi = regs_q[6];
  assign rdi = regs_q[7];
  assign r8  = regs_q[8];
  assign r9  = regs_q[9];
  assign r10 = regs_q[10];
  assign r11 = regs_q[11];
  assign r12 = regs_q[12];
  assign r13 = regs_q[13];
  assign r14 = regs_q[14];

endmodule

// File: tb/tb_seq_writeback.sv
// Bench for seq_writeback: instruction table plus hand-written exception, reset, saturation and bypass sequences.
module tb_seq_writeback;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wb_valid = 1'b0;
  logic [3:0]       icode = '0, rA = 4'hF, rB = 4'hF;
  logic             cnd = 1'b0;
  logic [XLEN-1:0]  valE = '0, valM = '0;
  logic             halt = 1'b0, invalid_instr = 1'b0, dmem_error = 1'b0;
  logic [3:0]       srcA = 4'hF, srcB = 4'hF;
  logic [XLEN-1:0]  rdA, rdB;
  logic [XLEN-1:0]  dut_r [15];
  logic [2:0]       stat;
  logic [CNT_W-1:0] retired;

  seq_writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .halt(halt), .invalid_instr(invalid_instr),
    .dmem_error(dmem_error), .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB),
    .rax(dut_r[0]), .rcx(dut_r[1]), .rdx(dut_r[2]), .rbx(dut_r[3]), .rsp(dut_r[4]),
    .rbp(dut_r[5]), .rsi(dut_r[6]), .rdi(dut_r[7]), .r8(dut_r[8]), .r9(dut_r[9]),
    .r10(dut_r[10]), .r11(dut_r[11]), .r12(dut_r[12]), .r13(dut_r[13]), .r14(dut_r[14]),
    .stat(stat), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0]  exp_q[$];
  logic [XLEN-1:0]  m_regs [15];
  logic [2:0]       m_stat;
  logic [CNT_W-1:0] m_ret;

  typedef struct {
    logic            v;
    logic [3:0]      ic, ra, rb;
    logic            c;
    logic [XLEN-1:0] ve, vm;
    logic [2:0]      fl;     // {dmem_error, invalid_instr, halt}
    logic [3:0]      e_idx;
    logic [XLEN-1:0] e_val;
    logic [3:0]      m_idx;
    logic [XLEN-1:0] m_val;
    logic [2:0]      e_stat;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_stat = AOK;
    m_ret  = '0;
  endtask

  // Apply expected effects of one retiring slot; writes listed only when they should happen.
  task automatic model_step(input logic v, input logic [3:0] e_idx, input logic [XLEN-1:0] e_val,
                            input logic [3:0] m_idx, input logic [XLEN-1:0] m_val, input logic [2:0] e_stat);
    if (v && m_stat == AOK) begin
      if (e_stat == AOK) begin
        if (m_ret != {CNT_W{1'b1}}) m_ret = m_ret + 1'b1;
        if (e_idx != 4'hF) m_regs[e_idx] = e_val;
        if (m_idx != 4'hF) m_regs[m_idx] = m_val;
      end
      m_stat = e_stat;
    end
  endtask

  task automatic push_expect();
    for (int i = 0; i < 15; i++) exp_q.push_back(m_regs[i]);
    exp_q.push_back(XLEN'(m_stat));
    exp_q.push_back(XLEN'(m_ret));
  endtask

  task automatic pop_check(input string tag);
    logic [XLEN-1:0] e;
    for (int i = 0; i < 17; i++) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s scoreboard: queue empty, wanted entry %0d", tag, i);
        return;
      end
      e = exp_q.pop_front();
      if (i < 15)       check($sformatf("%s reg[%0d]", tag, i), dut_r[i], e);
      else if (i == 15) check($sformatf("%s stat", tag), XLEN'(stat), e);
      else              check($sformatf("%s retired", tag), XLEN'(retired), e);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, ra, rb, input logic c,
                       input logic [XLEN-1:0] ve, vm, input logic [2:0] fl);
    wb_valid = v; icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
    {dmem_error, invalid_instr, halt} = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    {dmem_error, invalid_instr, halt} = 3'b000;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [XLEN-1:0] rv;
    int r, kind;

    tbl[0]  = '{1, 4'h3, 4'hF, 4'h0, 0, 64'h2A,  64'h0,    3'b000, 4'h0, 64'h2A,  4'hF, 64'h0,  AOK};
    tbl[1]  = '{1, 4'h2, 4'hF, 4'h3, 0, 64'h5,   64'h0,    3'b000, 4'hF, 64'h0,   4'hF, 64'h0,  AOK};
    tbl[2]  = '{1, 4'h2, 4'hF, 4'h3, 1, 64'h5,   64'h0,    3'b000, 4'h3, 64'h5,   4'hF, 64'h0,  AOK};
    tbl[3]  = '{1, 4'hB, 4'h4, 4'hF, 0, 64'h108, 64'h77,   3'b000, 4'hF, 64'h0,   4'h4, 64'h77, AOK};
    tbl[4]  = '{1, 4'hB, 4'h0, 4'hF, 0, 64'h108, 64'h77,   3'b000, 4'h4, 64'h108, 4'h0, 64'h77, AOK};
    tbl[5]  = '{1, 4'h6, 4'h1, 4'h6, 0, 64'h9,   64'h0,    3'b000, 4'h6, 64'h9,   4'hF, 64'h0,  AOK};
    tbl[6]  = '{1, 4'h5, 4'h1, 4'h2, 0, 64'hAB,  64'h55,   3'b000, 4'hF, 64'h0,   4'h1, 64'h55, AOK};
    tbl[7]  = '{1, 4'hA, 4'h2, 4'hF, 0, 64'h100, 64'h0,    3'b000, 4'h4, 64'h100, 4'hF, 64'h0,  AOK};
    tbl[8]  = '{1, 4'h8, 4'hF, 4'hF, 0, 64'hF8,  64'h0,    3'b000, 4'h4, 64'hF8,  4'hF, 64'h0,  AOK};
    tbl[9]  = '{1, 4'h9, 4'hF, 4'hF, 0, 64'h100, 64'hDEAD, 3'b000, 4'h4, 64'h100, 4'hF, 64'h0,  AOK};
    tbl[10] = '{1, 4'h1, 4'h2, 4'h2, 1, 64'h31,  64'h32,   3'b000, 4'hF, 64'h0,   4'hF, 64'h0,  AOK};
    tbl[11] = '{1, 4'h4, 4'h1, 4'h2, 0, 64'h30,  64'h33,   3'b000, 4'hF, 64'h0,   4'hF, 64'h0,  AOK};
    tbl[12] = '{1, 4'h3, 4'hF, 4'hF, 0, 64'h99,  64'h0,    3'b000, 4'hF, 64'h0,   4'hF, 64'h0,  AOK};
    tbl[13] = '{1, 4'h7, 4'h5, 4'h5, 1, 64'h12,  64'h13,   3'b000, 4'hF, 64'h0,   4'hF, 64'h0,  AOK};
    tbl[14] = '{0, 4'h3, 4'hF, 4'h1, 0, 64'h11,  64'h0,    3'b000, 4'hF, 64'h0,   4'hF, 64'h0,  AOK};
    tbl[15] = '{1, 4'h5, 4'h1, 4'h2, 0, 64'h40,  64'h66,   3'b100, 4'hF, 64'h0,   4'hF, 64'h0,  ADR};
    tbl[16] = '{1, 4'h3, 4'hF, 4'h1, 0, 64'h77,  64'h0,    3'b000, 4'hF, 64'h0,   4'hF, 64'h0,  ADR};

    model_reset();
    repeat (2) @(negedge clk);
    push_expect();
    pop_check("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].ic, tbl[i].ra, tbl[i].rb, tbl[i].c, tbl[i].ve, tbl[i].vm, tbl[i].fl);
      model_step(tbl[i].v, tbl[i].e_idx, tbl[i].e_val, tbl[i].m_idx, tbl[i].m_val, tbl[i].e_stat);
      push_expect();
      tick();
      pop_check($sformatf("vec%0d", i));
    end

    // Asynchronous reset between edges must clear everything without a clock.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    push_expect();
    pop_check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      r    = $urandom_range(0, 14);
      kind = $urandom_range(0, 2);
      rv   = {$urandom, $urandom};
      if (kind == 0)      drive(1, 4'h3, 4'hF, 4'(r), 0, rv, ~rv, 3'b000);
      else if (kind == 1) drive(1, 4'h6, 4'hF, 4'(r), 0, rv, ~rv, 3'b000);
      else                drive(1, 4'h5, 4'(r), 4'hF, 0, ~rv, rv, 3'b000);
      model_step(1, 4'(r), rv, 4'hF, '0, AOK);
      push_expect();
      tick();
      pop_check($sformatf("rand%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      drive(1, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0, 3'b000);
      model_step(1, 4'hF, '0, 4'hF, '0, AOK);
      push_expect();
      tick();
      pop_check($sformatf("sat%0d", i));
    end

    do_reset();
    drive(1, 4'h3, 4'hF, 4'h2, 0, 64'h5, 64'h0, 3'b011);
    model_step(1, 4'hF, '0, 4'hF, '0, INS);
    push_expect();
    tick();
    pop_check("halt_inv");
    drive(1, 4'h3, 4'hF, 4'h1, 0, 64'h88, 64'h0, 3'b000);
    model_step(1, 4'hF, '0, 4'hF, '0, INS);
    push_expect();
    tick();
    pop_check("after_ins");

    do_reset();
    drive(1, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 3'b001);
    model_step(1, 4'hF, '0, 4'hF, '0, HLT);
    push_expect();
    tick();
    pop_check("halt");

    do_reset();
    drive(1, 4'h3, 4'hF, 4'h6, 0, 64'h3, 64'h0, 3'b000);
    model_step(1, 4'h6, 64'h3, 4'hF, '0, AOK);
    tick();
    drive(1, 4'h3, 4'hF, 4'h4, 0, 64'h40, 64'h0, 3'b000);
    model_step(1, 4'h4, 64'h40, 4'hF, '0, AOK);
    tick();

    srcA = 4'h6; srcB = 4'hF;
    drive(1, 4'h6, 4'h0, 4'h6, 0, 64'h9, 64'h0, 3'b000);
    #1;
`ifdef WB_BYPASS_EN
    check("byp_opq_rdA", rdA, 64'h9);
`else
    check("byp_opq_rdA", rdA, 64'h3);
`endif
    check("rdB_none", rdB, 64'h0);
    model_step(1, 4'h6, 64'h9, 4'hF, '0, AOK);
    push_expect();
    tick();
    pop_check("opq");
    check("rdA_after", rdA, 64'h9);

    srcA = 4'h4; srcB = 4'h6;
    drive(1, 4'hB, 4'h6, 4'hF, 0, 64'h200, 64'h300, 3'b000);
    #1;
`ifdef WB_BYPASS_EN
    check("byp_pop_rdA", rdA, 64'h200);
    check("byp_pop_rdB", rdB, 64'h300);
`else
    check("byp_pop_rdA", rdA, 64'h40);
    check("byp_pop_rdB", rdB, 64'h9);
`endif
    model_step(1, 4'h4, 64'h200, 4'h6, 64'h300, AOK);
    tick();

    srcA = 4'h4;
    drive(1, 4'hB, 4'h4, 4'hF, 0, 64'h208, 64'h500, 3'b000);
    #1;
`ifdef WB_BYPASS_EN
    check("byp_dbl_rdA", rdA, 64'h500);
`else
    check("byp_dbl_rdA", rdA, 64'h200);
`endif
    model_step(1, 4'hF, '0, 4'h4, 64'h500, AOK);
    tick();

    srcA = 4'h6; srcB = 4'h4;
    drive(1, 4'h3, 4'hF, 4'h6, 0, 64'h44, 64'h0, 3'b001);
    #1;
    check("byp_suppressed_rdA", rdA, 64'h300);
    model_step(1, 4'hF, '0, 4'hF, '0, HLT);
    push_expect();
    tick();
    pop_check("byp_halt");
    check("halted_rdB", rdB, 64'h500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
